// File: rtl/packet_pkg.sv
// Shared definitions for the ingress packet generator: FSM encoding,
// MAC constants, fixed packet words and request-word field positions.
package packet_pkg;

  // Word-emitting states keep the encodings the egress validator uses;
  // LOAD and TRAILER are generator-only states appended after them.
  typedef enum logic [3:0] {
    IDLE            = 4'b0000,
    LENGTH_DMAC_FST = 4'b0001,
    LENGTH_DMAC_SND = 4'b0010,
    TIME_FST        = 4'b0011,
    TIME_SND        = 4'b0100,
    SMAC_FST        = 4'b0101,
    SMAC_SND        = 4'b0110,
    PAYLOAD         = 4'b0111,
    LOAD            = 4'b1000,
    TRAILER         = 4'b1001
  } pkt_state_e;

  localparam logic [15:0] MAC_PREFIX   = 16'h0000;
  localparam logic [31:0] MAC_SUFFIX   = 32'h1234_5678;
  localparam logic [31:0] PAYLOAD_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] TRAILER_WORD = 32'h0000_0000;

  // Request word layout: [31:30] src, [29:28] dest, [27:22] length blocks.
  localparam int SRC_LSB = 30;
  localparam int DST_LSB = 28;
  localparam int LEN_LSB = 22;
  localparam int LEN_W   = 6;

  // Packet length in bytes; a zero block field stands for 64 blocks.
  function automatic logic [15:0] blocks_to_bytes(input logic [LEN_W-1:0] field,
                                                  input int block_size);
    logic [6:0] nblk;
    nblk = (field == '0) ? 7'd64 : {1'b0, field};
    return 16'(nblk) * 16'(block_size);
  endfunction

endpackage

// File: rtl/port_to_mac.sv
// Maps a 2-bit port number to its 48-bit MAC; inverse of mac_to_port.
module port_to_mac
  import packet_pkg::*;
(
  input  logic [1:0]  port,
  output logic [47:0] mac
);

  // Port number sits in MAC bits [33:32].
  assign mac = {MAC_PREFIX[13:0], port, MAC_SUFFIX};

endmodule

// File: rtl/simple_dual_port_mem.sv
// One write port, one read port with a registered read.
module simple_dual_port_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write on strobe; read data appears one cycle after the address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/packet_gen.sv
// Expands queued 32-bit request words into full packets on a
// valid/ready stream toward the crossbar ingress port.
module packet_gen
  import packet_pkg::*;
#(
  parameter int REQ_CNT    = 16,
  parameter int META_WIDTH = 32,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [META_WIDTH-1:0] ingress_in,
  input  logic                  ingress_in_en,
  output logic                  ingress_full,
  output logic [31:0]           ingress_out,
  output logic                  ingress_out_valid,
  input  logic                  ingress_out_ready,
  output logic [31:0]           pkt_sent_cnt
);

  // Handshake: a word transfers on any cycle with valid && ready. valid and
  // ingress_out are decoded from registered state only, so they never depend
  // combinationally on ready and stay stable while the crossbar stalls.

  localparam int IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_CNT - 1);

  pkt_state_e            state, next_state;
  logic [IDX_W-1:0]      start_idx, end_idx, start_idx_nxt, end_idx_nxt;
  logic [META_WIDTH-1:0] mem_q, req_reg;
  logic [31:0]           ts_cnt, ts_reg;
  logic [9:0]            word_cnt, last_word;
  logic [15:0]           len_bytes;
  logic [47:0]           dmac, smac;
  logic                  fifo_empty, wr_accept, xfer;
  logic                  unused_req_bits;

  assign start_idx_nxt = (start_idx == LAST_IDX) ? '0 : start_idx + IDX_W'(1);
  assign end_idx_nxt   = (end_idx == LAST_IDX) ? '0 : end_idx + IDX_W'(1);
  assign ingress_full  = (end_idx_nxt == start_idx);
  assign fifo_empty    = (start_idx == end_idx);
  assign wr_accept     = ingress_in_en && !ingress_full;
  assign xfer          = ingress_out_valid && ingress_out_ready;

  assign len_bytes       = blocks_to_bytes(req_reg[LEN_LSB +: LEN_W], BLOCK_SIZE);
  assign last_word       = len_bytes[11:2] - 10'd1;
  assign unused_req_bits = ^req_reg[LEN_LSB-1:0];

  simple_dual_port_mem #(
    .DATA_WIDTH (META_WIDTH),
    .DEPTH      (REQ_CNT),
    .ADDR_WIDTH (IDX_W)
  ) u_req_mem (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (end_idx),
    .wr_data (ingress_in),
    .rd_addr (start_idx),
    .rd_data (mem_q)
  );

  port_to_mac u_dmac (.port(req_reg[DST_LSB +: 2]), .mac(dmac));
  port_to_mac u_smac (.port(req_reg[SRC_LSB +: 2]), .mac(smac));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next state: word states advance only when their word transfers.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:            if (!fifo_empty) next_state = LOAD;
      LOAD:            next_state = LENGTH_DMAC_FST;
      LENGTH_DMAC_FST: if (xfer) next_state = LENGTH_DMAC_SND;
      LENGTH_DMAC_SND: if (xfer) next_state = TIME_FST;
      TIME_FST:        if (xfer) next_state = TIME_SND;
      TIME_SND:        if (xfer) next_state = SMAC_FST;
      SMAC_FST:        if (xfer) next_state = SMAC_SND;
      SMAC_SND:        if (xfer) next_state = PAYLOAD;
      PAYLOAD:         if (xfer && word_cnt == last_word) next_state = TRAILER;
      TRAILER:         if (xfer) next_state = IDLE;
      default:         next_state = IDLE;
    endcase
  end

  // Output decode: the word presented in each state.
  always_comb begin
    ingress_out_valid = 1'b1;
    ingress_out       = '0;
    case (state)
      LENGTH_DMAC_FST: ingress_out = {len_bytes, dmac[47:32]};
      LENGTH_DMAC_SND: ingress_out = dmac[31:0];
      TIME_FST:        ingress_out = ts_reg;
      TIME_SND:        ingress_out = 32'h0;
      SMAC_FST:        ingress_out = {16'h0, smac[47:32]};
      SMAC_SND:        ingress_out = smac[31:0];
      PAYLOAD:         ingress_out = PAYLOAD_WORD;
      TRAILER:         ingress_out = TRAILER_WORD;
      default:         ingress_out_valid = 1'b0;
    endcase
  end

  // Datapath: FIFO indices, timestamp, request latch, word and packet counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_idx    <= '0;
      end_idx      <= '0;
      ts_cnt       <= '0;
      ts_reg       <= '0;
      req_reg      <= '0;
      word_cnt     <= '0;
      pkt_sent_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (wr_accept) end_idx <= end_idx_nxt;
      if (state == LOAD) begin
        req_reg   <= mem_q;
        ts_reg    <= ts_cnt;
        start_idx <= start_idx_nxt;
      end
      // word_cnt holds the index of the word on the bus during PAYLOAD.
      if (state == SMAC_SND && xfer)     word_cnt <= 10'd6;
      else if (state == PAYLOAD && xfer) word_cnt <= word_cnt + 10'd1;
      if (state == TRAILER && xfer) pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_packet_gen.sv
// Bench for packet_gen: reference model expands each accepted request into
// its expected word stream; a monitor pops and compares on every transfer.
module tb_packet_gen;
  import packet_pkg::*;

  localparam int REQ_CNT = 16;
  localparam int W       = 34;  // [33] trailer marker, [32] timestamp slot

  logic        clk, reset;
  logic [31:0] ingress_in;
  logic        ingress_in_en, ingress_full;
  logic [31:0] ingress_out;
  logic        ingress_out_valid, ingress_out_ready;
  logic [31:0] pkt_sent_cnt;

  int          checks = 0;
  int          passes = 0;
  logic [W-1:0] exp_q[$];
  int          fifo_cnt = 0;
  int          sent_model = 0;
  int          rdy_mode = 0;   // 0 always ready, 1 random, 2 never
  int          pkt_word = 0;
  logic [31:0] tb_cyc, w0_cyc, last_ts, last_wr_cyc;

  packet_gen #(.REQ_CNT(REQ_CNT), .META_WIDTH(32), .BLOCK_SIZE(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .ingress_in        (ingress_in),
    .ingress_in_en     (ingress_in_en),
    .ingress_full      (ingress_full),
    .ingress_out       (ingress_out),
    .ingress_out_valid (ingress_out_valid),
    .ingress_out_ready (ingress_out_ready),
    .pkt_sent_cnt      (pkt_sent_cnt)
  );

  // Clock and cycle reference (cycles since reset release).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!reset) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: the complete word list a request must produce.
  function automatic void push_packet(input logic [31:0] req);
    logic [5:0]  fld;
    logic [1:0]  src, dst;
    logic [15:0] pre;
    logic [31:0] suf;
    logic [47:0] dmac, smac;
    int nblk, nbytes, nwords;
    fld    = req[27:22];
    src    = req[31:30];
    dst    = req[29:28];
    nblk   = (fld == 6'd0) ? 64 : int'(fld);
    nbytes = nblk * 32;
    nwords = nbytes / 4;
    pre    = MAC_PREFIX;
    suf    = MAC_SUFFIX;
    dmac   = {pre[13:0], dst, suf};
    smac   = {pre[13:0], src, suf};
    exp_q.push_back({2'b00, nbytes[15:0], dmac[47:32]});
    exp_q.push_back({2'b00, dmac[31:0]});
    exp_q.push_back({2'b01, 32'h0});
    exp_q.push_back({2'b00, 32'h0});
    exp_q.push_back({2'b00, 16'h0, smac[47:32]});
    exp_q.push_back({2'b00, smac[31:0]});
    for (int i = 6; i < nwords; i++) exp_q.push_back({2'b00, 32'hFFFF_FFFF});
    exp_q.push_back({2'b10, 32'h0});
  endfunction

  // Driver: one write strobe; the model decides whether it is accepted.
  task automatic write_req(input logic [31:0] req, input bit check_full);
    bit exp_full;
    @(negedge clk);
    exp_full = (fifo_cnt >= REQ_CNT - 1);
    if (check_full) check("ingress_full", 32'(ingress_full), 32'(exp_full));
    ingress_in    = req;
    ingress_in_en = 1'b1;
    last_wr_cyc   = tb_cyc;
    if (!exp_full) begin
      fifo_cnt++;
      push_packet(req);
    end
    @(negedge clk);
    ingress_in_en = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_cnt != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: drives ready, checks stall stability, gap and every transferred word.
  initial begin
    bit          stall, prev_v, seen_pkt;
    logic [31:0] held;
    int          idle_run;
    logic [W-1:0] e;
    stall = 0; prev_v = 0; seen_pkt = 0; held = '0; idle_run = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall = 0; prev_v = 0; seen_pkt = 0; idle_run = 0; pkt_word = 0;
        continue;
      end
      case (rdy_mode)
        0:       ingress_out_ready = 1'b1;
        1:       ingress_out_ready = ($urandom_range(0, 99) < 55);
        default: ingress_out_ready = 1'b0;
      endcase
      if (stall) begin
        check("stall_valid", 32'(ingress_out_valid), 32'd1);
        check("stall_data", ingress_out, held);
      end
      if (ingress_out_valid && !prev_v) begin
        fifo_cnt--;
        w0_cyc   = tb_cyc;
        pkt_word = 0;
        if (seen_pkt) check("gap_ge2", 32'(idle_run >= 2), 32'd1);
        seen_pkt = 1;
      end
      if (!ingress_out_valid) idle_run++;
      else                    idle_run = 0;
      if (ingress_out_valid && ingress_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          if (e[32]) begin
            check("timestamp", ingress_out, w0_cyc - 32'd1);
            last_ts = ingress_out;
          end else begin
            check($sformatf("word%0d", pkt_word), ingress_out, e[31:0]);
          end
          if (e[33]) begin
            check("pkt_sent_cnt_at_trailer", pkt_sent_cnt, 32'(sent_model));
            sent_model++;
          end
        end
        pkt_word++;
      end
      stall  = ingress_out_valid && !ingress_out_ready;
      held   = ingress_out;
      prev_v = ingress_out_valid;
    end
  end

  // Stimulus sequence.
  initial begin
    logic [31:0] req;
    int          n;
    bit          saw;
    reset = 1'b0; ingress_in = '0; ingress_in_en = 1'b0; ingress_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(ingress_out_valid), 32'd0);
    check("rst_out", ingress_out, 32'd0);
    check("rst_full", 32'(ingress_full), 32'd0);
    check("rst_pkt_cnt", pkt_sent_cnt, 32'd0);
    reset = 1'b1;

    // Single one-block packet, no backpressure.
    rdy_mode = 0;
    write_req(32'h6040_0000, 1'b0);
    wait_drain(200, "drain_single");
    check("pkt_cnt_single", pkt_sent_cnt, 32'd1);

    // Length field 0 encodes 64 blocks: 512 data words + trailer.
    write_req(32'h9000_0000, 1'b0);
    wait_drain(2000, "drain_len0");

    // Three-block packet under random backpressure.
    rdy_mode = 1;
    write_req({2'd3, 2'd0, 6'd3, 22'h2A_AAAA}, 1'b0);
    wait_drain(500, "drain_bp3");

    // Random requests with random gaps.
    for (int i = 0; i < 20; i++) begin
      n = 0;
      while (fifo_cnt >= 4 && n < 5000) begin @(negedge clk); n++; end
      req        = $urandom;
      req[27:22] = 6'($urandom_range(1, 8));
      write_req(req, 1'b0);
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    wait_drain(20000, "drain_random");

    // Fill: one packet stalled on the bus, then 16 writes into the FIFO.
    rdy_mode = 2;
    write_req({2'd1, 2'd3, 6'd2, 22'h0}, 1'b0);
    n = 0;
    while (fifo_cnt != 0 && n < 50) begin @(negedge clk); n++; end
    check("fill_first_started", 32'(fifo_cnt), 32'd0);
    for (int i = 0; i < 16; i++) begin
      req        = $urandom;
      req[27:22] = 6'(1 + i % 8);
      write_req(req, 1'b1);
    end
    check("full_after_15", 32'(ingress_full), 32'd1);
    rdy_mode = 1;
    wait_drain(20000, "drain_fill");
    check("full_after_drain", 32'(ingress_full), 32'd0);
    check("pkt_cnt_total", pkt_sent_cnt, 32'(sent_model));

    // Reset in the middle of a payload with more requests queued.
    rdy_mode = 0;
    write_req({2'd0, 2'd1, 6'd8, 22'h0}, 1'b0);
    write_req({2'd2, 2'd2, 6'd2, 22'h0}, 1'b0);
    write_req({2'd3, 2'd3, 6'd3, 22'h0}, 1'b0);
    n = 0;
    while (pkt_word < 10 && n < 200) begin @(negedge clk); n++; end
    check("reached_payload", 32'(pkt_word >= 10), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
    fifo_cnt   = 0;
    sent_model = 0;
    check("midrst_valid", 32'(ingress_out_valid), 32'd0);
    check("midrst_out", ingress_out, 32'd0);
    check("midrst_pkt_cnt", pkt_sent_cnt, 32'd0);
    check("midrst_full", 32'(ingress_full), 32'd0);
    reset = 1'b1;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (ingress_out_valid) saw = 1;
    end
    check("fifo_empty_after_reset", 32'(saw), 32'd0);
    write_req({2'd1, 2'd2, 6'd1, 22'h0}, 1'b0);
    wait_drain(200, "drain_after_reset");
    check("ts_after_reset", last_ts, last_wr_cyc + 32'd2);
    check("pkt_cnt_after_reset", pkt_sent_cnt, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
